sh_bsc_ext: RTL and testbench
=============================

SH_BSC_EXT -- requirements
Module: sh_bsc_ext

Interface
REQ-001: CLK  in  1  system clock; all sequential logic on rising edge.
REQ-002: RST  in  1  asynchronous, active-high reset.
REQ-003: CE  in  1  clock enable; the state machine, counters and registers advance only when CE=1.
REQ-004: DBUS_A  in  32  master address; DBUS_DO  in  32  master write data; DBUS_BA  in  4  byte lanes; DBUS_WE  in  1; DBUS_REQ  in  1; DBUS_LOCK  in  1.
REQ-005: DBUS_DI  out  32  read data (registered); DBUS_WAIT  out  1  stall to master; BSC_ACK  out  1  external data phase active.
REQ-006: MEM_A  out  27  external address; MEM_DO  out  32; MEM_DI  in  32; MEM_BE_N  out  4; MEM_RD_N  out  1; MEM_WR_N  out  1; CS_N  out  4; MEM_WAIT_N  in  1.
REQ-007: REG_WE  in  1; REG_DI  in  16; REG_DO  out  16  wait-control register (WCR) port.

Function
REQ-008: Request is valid when DBUS_REQ=1 and DBUS_A[31:29] is 000 or 001; area n = DBUS_A[28:27].
REQ-009: Invalid-space requests (e.g. FFFFFE71) shall start no external cycle and leave DBUS_WAIT=0.
REQ-010: WCR[7:0] holds wait counts; W[n] = WCR[2n+1:2n] (0..3); REG_DO = {8'h00, WCR[7:0]}; WCR[15:8] reads 0 and ignores writes.
REQ-011: A REG_WE write (CE=1) shall take effect on the next edge; the count already loaded for an in-flight cycle shall be unaffected.
REQ-012: FSM states: IDLE, T1, TW, T2.
REQ-013: IDLE: on a valid request, latch DBUS_A[26:0], DBUS_DO, ~DBUS_BA, DBUS_WE and area, load WCNT=W[area], and go to T1.
REQ-014: T1: go to TW if WCNT!=0, else T2.
REQ-015: TW: decrement WCNT each enabled cycle; exit to T2 only when WCNT==1 at decrement (reaching 0) and MEM_WAIT_N=1.
REQ-016: TW: while MEM_WAIT_N=0 at WCNT=0, stay in TW (unbounded extension).
REQ-017: T2: BSC_ACK=1; on reads, DBUS_DI <= MEM_DI at the T2 edge and hold it until the next read T2.
REQ-018: T2 exit: if DBUS_REQ=1, DBUS_LOCK=1 and the request is valid, latch the new request and go directly to T1 (no IDLE cycle); otherwise go to IDLE.
REQ-019: During T1/TW/T2: CS_N[area]=0 with other bits 1; MEM_RD_N=~(~WE) and MEM_WR_N=~WE, i.e. the selected strobe low; MEM_A, MEM_DO and MEM_BE_N driven from latches.
REQ-020: In IDLE, all strobes and CS_N shall be 1.
REQ-021: All external outputs shall be registered (glitch-free).
REQ-022: DBUS_WAIT = (IDLE and valid request) or state in {T1, TW}; DBUS_WAIT=0 in T2 so the master advances on that edge.
REQ-023: Minimum access = 2 cycles (T1, T2); total = 2 + W[n] + external wait cycles.
REQ-024: With CE=0, all state and outputs shall hold.
REQ-025: A request arriving in T2 without lock shall be serviced from IDLE on the following cycle.

Reset
REQ-026: RST=1 shall immediately force: state IDLE, CS_N=4'hF, MEM_RD_N=1, MEM_WR_N=1, MEM_BE_N=4'hF, BSC_ACK=0, DBUS_DI=0, MEM_A=0, MEM_DO=0, WCNT=0, WCR[7:0]=8'hFF.
REQ-027: Reset asserted mid-cycle (T1/TW/T2) shall abort the cycle without completing it, and no ACK shall be issued.

Verification
REQ-028: Reset -> CS_N=F, RD_N=WR_N=1, BSC_ACK=0, REG_DO=00FF, DBUS_WAIT=0 with REQ=0.
REQ-029: WCR=00, read A=0x00000100, MEM_DI=12345678 -> T1, T2 (2 cycles); CS_N=E; ACK in cycle 2; DBUS_DI=12345678.
REQ-030: WCR=20, write A=0x10000040, DO=CAFEBABE, BA=3 -> CS_N=B; WR_N low 4 cycles; MEM_BE_N=C; MEM_DO=CAFEBABE.
REQ-031: W0=1, MEM_WAIT_N low for 3 cycles in TW -> access lasts 6 cycles; DBUS_WAIT stays high until T2.
REQ-032: 4 locked reads with W0=0 -> 8 consecutive cycles; CS_N held low throughout; 4 ACK pulses; no IDLE between beats.
REQ-033: RST asserted in TW -> strobes high asynchronously, no ACK; request to 0xFFFFFE71 -> no CS_N activity, DBUS_WAIT=0.

Source files
------------

// File: rtl/sh_bsc_ext.sv
// External bus state controller: maps the master data bus onto four chip-select areas
// with per-area programmable wait states, external wait extension and locked back-to-back beats.
module sh_bsc_ext (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CE,
   input  logic [31:0] DBUS_A,
   input  logic [31:0] DBUS_DO,
   input  logic [3:0]  DBUS_BA,
   input  logic        DBUS_WE,
   input  logic        DBUS_REQ,
   input  logic        DBUS_LOCK,
   output logic [31:0] DBUS_DI,
   output logic        DBUS_WAIT,
   output logic        BSC_ACK,
   output logic [26:0] MEM_A,
   output logic [31:0] MEM_DO,
   input  logic [31:0] MEM_DI,
   output logic [3:0]  MEM_BE_N,
   output logic        MEM_RD_N,
   output logic        MEM_WR_N,
   output logic [3:0]  CS_N,
   input  logic        MEM_WAIT_N,
   input  logic        REG_WE,
   input  logic [15:0] REG_DI,
   output logic [15:0] REG_DO
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_T1   = 2'd1,
      ST_TW   = 2'd2,
      ST_T2   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  wcnt_q, wcnt_d;
   logic [7:0]  wcr_q, wcr_d;
   logic [26:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_n_q, be_n_d;
   logic        we_q, we_d;
   logic [1:0]  area_q, area_d;
   logic [3:0]  cs_n_q, cs_n_d;
   logic        rd_n_q, rd_n_d;
   logic        wr_n_q, wr_n_d;
   logic        ack_q, ack_d;
   logic [31:0] rdata_q, rdata_d;
   logic        req_valid_s;
   logic        load_s;
   logic        unused_reg_hi_s;

   function automatic logic [1:0] wait_count(input logic [7:0] wcr, input logic [1:0] area);
      logic [1:0] cnt;
      case (area)
         2'd0:    cnt = wcr[1:0];
         2'd1:    cnt = wcr[3:2];
         2'd2:    cnt = wcr[5:4];
         2'd3:    cnt = wcr[7:6];
         default: cnt = 2'd3;
      endcase
      return cnt;
   endfunction

   function automatic logic [3:0] cs_decode(input logic [1:0] area);
      logic [3:0] cs_n;
      case (area)
         2'd0:    cs_n = 4'b1110;
         2'd1:    cs_n = 4'b1101;
         2'd2:    cs_n = 4'b1011;
         2'd3:    cs_n = 4'b0111;
         default: cs_n = 4'b1111;
      endcase
      return cs_n;
   endfunction

   assign unused_reg_hi_s = ^REG_DI[15:8];

   // Only the two lowest 512 MB spaces belong to the external bus.
   always_comb begin
      req_valid_s = DBUS_REQ & ((DBUS_A[31:29] == 3'b000) | (DBUS_A[31:29] == 3'b001));
   end

   // Next-state, latch and registered-output computation.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      wcr_d   = wcr_q;
      rdata_d = rdata_q;
      load_s  = 1'b0;
      if (CE) begin
         if (REG_WE) begin
            wcr_d = REG_DI[7:0];
         end else begin
            wcr_d = wcr_q;
         end
         case (state_q)
            ST_IDLE: begin
               if (req_valid_s) begin
                  state_d = ST_T1;
                  load_s  = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_T1: begin
               if (wcnt_q != 2'd0) begin
                  state_d = ST_TW;
               end else begin
                  state_d = ST_T2;
               end
            end
            ST_TW: begin
               if (wcnt_q != 2'd0) begin
                  wcnt_d = wcnt_q - 2'd1;
               end else begin
                  wcnt_d = 2'd0;
               end
               // Leave only once the programmed count is used up and the device is ready.
               if ((wcnt_q <= 2'd1) && MEM_WAIT_N) begin
                  state_d = ST_T2;
               end else begin
                  state_d = ST_TW;
               end
            end
            ST_T2: begin
               if (!we_q) begin
                  rdata_d = MEM_DI;
               end else begin
                  rdata_d = rdata_q;
               end
               if (req_valid_s && DBUS_LOCK) begin
                  state_d = ST_T1;
                  load_s  = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         wcr_d = wcr_q;
      end

      if (load_s) begin
         addr_d  = DBUS_A[26:0];
         wdata_d = DBUS_DO;
         be_n_d  = ~DBUS_BA;
         we_d    = DBUS_WE;
         area_d  = DBUS_A[28:27];
         wcnt_d  = wait_count(wcr_q, DBUS_A[28:27]);
      end else begin
         addr_d  = addr_q;
         wdata_d = wdata_q;
         be_n_d  = be_n_q;
         we_d    = we_q;
         area_d  = area_q;
      end

      // Strobes follow the state being entered so they change cleanly on the edge.
      if (state_d != ST_IDLE) begin
         cs_n_d = cs_decode(area_d);
         rd_n_d = we_d;
         wr_n_d = ~we_d;
      end else begin
         cs_n_d = 4'hF;
         rd_n_d = 1'b1;
         wr_n_d = 1'b1;
      end
      ack_d = (state_d == ST_T2);
   end

   // State, latched request and registered external outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         wcnt_q  <= 2'd0;
         wcr_q   <= 8'hFF;
         addr_q  <= 27'd0;
         wdata_q <= 32'd0;
         be_n_q  <= 4'hF;
         we_q    <= 1'b0;
         area_q  <= 2'd0;
         cs_n_q  <= 4'hF;
         rd_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         ack_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         wcr_q   <= wcr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_n_q  <= be_n_d;
         we_q    <= we_d;
         area_q  <= area_d;
         cs_n_q  <= cs_n_d;
         rd_n_q  <= rd_n_d;
         wr_n_q  <= wr_n_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
      end
   end

   assign DBUS_WAIT = ((state_q == ST_IDLE) && req_valid_s) ||
                      (state_q == ST_T1) || (state_q == ST_TW);
   assign DBUS_DI   = rdata_q;
   assign BSC_ACK   = ack_q;
   assign MEM_A     = addr_q;
   assign MEM_DO    = wdata_q;
   assign MEM_BE_N  = be_n_q;
   assign MEM_RD_N  = rd_n_q;
   assign MEM_WR_N  = wr_n_q;
   assign CS_N      = cs_n_q;
   assign REG_DO    = {8'h00, wcr_q};

endmodule

// File: tb/tb_sh_bsc_ext.sv
// Directed, table-driven bench for sh_bsc_ext: one record per clock cycle of inputs and
// expected outputs, followed by a hand-written reset-during-wait-state sequence.
module tb_sh_bsc_ext;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CE;
   logic [31:0] DBUS_A;
   logic [31:0] DBUS_DO;
   logic [3:0]  DBUS_BA;
   logic        DBUS_WE;
   logic        DBUS_REQ;
   logic        DBUS_LOCK;
   logic [31:0] DBUS_DI;
   logic        DBUS_WAIT;
   logic        BSC_ACK;
   logic [26:0] MEM_A;
   logic [31:0] MEM_DO;
   logic [31:0] MEM_DI;
   logic [3:0]  MEM_BE_N;
   logic        MEM_RD_N;
   logic        MEM_WR_N;
   logic [3:0]  CS_N;
   logic        MEM_WAIT_N;
   logic        REG_WE;
   logic [15:0] REG_DI;
   logic [15:0] REG_DO;

   int n_checks = 0;
   int n_errors = 0;

   sh_bsc_ext dut (
      .CLK(CLK), .RST(RST), .CE(CE),
      .DBUS_A(DBUS_A), .DBUS_DO(DBUS_DO), .DBUS_BA(DBUS_BA), .DBUS_WE(DBUS_WE),
      .DBUS_REQ(DBUS_REQ), .DBUS_LOCK(DBUS_LOCK),
      .DBUS_DI(DBUS_DI), .DBUS_WAIT(DBUS_WAIT), .BSC_ACK(BSC_ACK),
      .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_DI(MEM_DI), .MEM_BE_N(MEM_BE_N),
      .MEM_RD_N(MEM_RD_N), .MEM_WR_N(MEM_WR_N), .CS_N(CS_N), .MEM_WAIT_N(MEM_WAIT_N),
      .REG_WE(REG_WE), .REG_DI(REG_DI), .REG_DO(REG_DO)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        ce, req, lock, we;
      logic [31:0] a, dout;
      logic [3:0]  ba;
      logic        wn;
      logic [31:0] mdi;
      logic        rwe;
      logic [15:0] rdi;
      logic [3:0]  e_cs;
      logic        e_rd, e_wr, e_ack, e_wt;
      logic [31:0] e_di;
      logic [15:0] e_reg;
      logic        chk_bus;
      logic [26:0] e_a;
      logic [31:0] e_do;
      logic [3:0]  e_be;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic ce, input logic req, input logic lock, input logic we,
                      input logic [31:0] a, input logic [31:0] dout, input logic [3:0] ba,
                      input logic wn, input logic [31:0] mdi, input logic rwe,
                      input logic [15:0] rdi, input logic [3:0] cs, input logic rd,
                      input logic wr, input logic ack, input logic wt,
                      input logic [31:0] di, input logic [15:0] rg);
      vec_t v;
      v.ce = ce; v.req = req; v.lock = lock; v.we = we; v.a = a; v.dout = dout; v.ba = ba;
      v.wn = wn; v.mdi = mdi; v.rwe = rwe; v.rdi = rdi;
      v.e_cs = cs; v.e_rd = rd; v.e_wr = wr; v.e_ack = ack; v.e_wt = wt; v.e_di = di;
      v.e_reg = rg; v.chk_bus = 1'b0; v.e_a = 27'd0; v.e_do = 32'd0; v.e_be = 4'hF;
      tv.push_back(v);
   endtask

   task automatic bus(input logic [26:0] a, input logic [31:0] dout, input logic [3:0] be);
      int last;
      last = tv.size() - 1;
      tv[last].chk_bus = 1'b1;
      tv[last].e_a     = a;
      tv[last].e_do    = dout;
      tv[last].e_be    = be;
   endtask

   task automatic drive_idle();
      CE = 1'b1; DBUS_REQ = 1'b0; DBUS_LOCK = 1'b0; DBUS_WE = 1'b0; DBUS_A = 32'd0;
      DBUS_DO = 32'd0; DBUS_BA = 4'hF; MEM_WAIT_N = 1'b1; MEM_DI = 32'd0;
      REG_WE = 1'b0; REG_DI = 16'd0;
   endtask

   initial begin
      RST = 1'b1;
      drive_idle();

      // ce req lk we  a             dout          ba    wn  mdi           rwe rdi       | cs    rd wr ak wt di            reg
      // reset state, then WCR write (upper byte ignored)
      add(1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hF,1'b1,1'b1,1'b0,1'b0,32'h0000_0000,16'h00FF);
      add(1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b1,16'hFF00, 4'hF,1'b1,1'b1,1'b0,1'b0,32'h0000_0000,16'h00FF);
      // zero-wait read, area 0
      add(1'b1,1'b1,1'b0,1'b0,32'h0000_0100,32'h0000_0000,4'hF,1'b1,32'h1234_5678,1'b0,16'h0000, 4'hF,1'b1,1'b1,1'b0,1'b1,32'h0000_0000,16'h0000);
      add(1'b1,1'b1,1'b0,1'b0,32'h0000_0100,32'h0000_0000,4'hF,1'b1,32'h1234_5678,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b0,1'b1,32'h0000_0000,16'h0000);
      add(1'b1,1'b0,1'b0,1'b0,32'h0000_0100,32'h0000_0000,4'hF,1'b1,32'h1234_5678,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b1,1'b0,32'h0000_0000,16'h0000);
      // WCR=20, write to area 2 with two wait states
      add(1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b1,16'h0020, 4'hF,1'b1,1'b1,1'b0,1'b0,32'h1234_5678,16'h0000);
      add(1'b1,1'b1,1'b0,1'b1,32'h1000_0040,32'hCAFE_BABE,4'h3,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hF,1'b1,1'b1,1'b0,1'b1,32'h1234_5678,16'h0020);
      add(1'b1,1'b1,1'b0,1'b1,32'h1000_0040,32'hCAFE_BABE,4'h3,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hB,1'b1,1'b0,1'b0,1'b1,32'h1234_5678,16'h0020);
      bus(27'h000_0040, 32'hCAFE_BABE, 4'hC);
      add(1'b1,1'b1,1'b0,1'b1,32'h1000_0040,32'hCAFE_BABE,4'h3,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hB,1'b1,1'b0,1'b0,1'b1,32'h1234_5678,16'h0020);
      add(1'b1,1'b1,1'b0,1'b1,32'h1000_0040,32'hCAFE_BABE,4'h3,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hB,1'b1,1'b0,1'b0,1'b1,32'h1234_5678,16'h0020);
      add(1'b1,1'b0,1'b0,1'b1,32'h1000_0040,32'hCAFE_BABE,4'h3,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hB,1'b1,1'b0,1'b1,1'b0,32'h1234_5678,16'h0020);
      // W0=1 read stretched by three external wait cycles
      add(1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b1,16'h0021, 4'hF,1'b1,1'b1,1'b0,1'b0,32'h1234_5678,16'h0020);
      add(1'b1,1'b1,1'b0,1'b0,32'h0000_0200,32'h0000_0000,4'hF,1'b1,32'hDEAD_BEEF,1'b0,16'h0000, 4'hF,1'b1,1'b1,1'b0,1'b1,32'h1234_5678,16'h0021);
      add(1'b1,1'b1,1'b0,1'b0,32'h0000_0200,32'h0000_0000,4'hF,1'b1,32'hDEAD_BEEF,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b0,1'b1,32'h1234_5678,16'h0021);
      add(1'b1,1'b1,1'b0,1'b0,32'h0000_0200,32'h0000_0000,4'hF,1'b0,32'hDEAD_BEEF,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b0,1'b1,32'h1234_5678,16'h0021);
      add(1'b1,1'b1,1'b0,1'b0,32'h0000_0200,32'h0000_0000,4'hF,1'b0,32'hDEAD_BEEF,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b0,1'b1,32'h1234_5678,16'h0021);
      add(1'b1,1'b1,1'b0,1'b0,32'h0000_0200,32'h0000_0000,4'hF,1'b0,32'hDEAD_BEEF,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b0,1'b1,32'h1234_5678,16'h0021);
      add(1'b1,1'b1,1'b0,1'b0,32'h0000_0200,32'h0000_0000,4'hF,1'b1,32'hDEAD_BEEF,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b0,1'b1,32'h1234_5678,16'h0021);
      add(1'b1,1'b0,1'b0,1'b0,32'h0000_0200,32'h0000_0000,4'hF,1'b1,32'hDEAD_BEEF,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b1,1'b0,32'h1234_5678,16'h0021);
      // four locked zero-wait reads
      add(1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b1,16'h0020, 4'hF,1'b1,1'b1,1'b0,1'b0,32'hDEAD_BEEF,16'h0021);
      add(1'b1,1'b1,1'b1,1'b0,32'h0000_0300,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hF,1'b1,1'b1,1'b0,1'b1,32'hDEAD_BEEF,16'h0020);
      add(1'b1,1'b1,1'b1,1'b0,32'h0000_0300,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b0,1'b1,32'hDEAD_BEEF,16'h0020);
      add(1'b1,1'b1,1'b1,1'b0,32'h0000_0304,32'h0000_0000,4'hF,1'b1,32'h1111_0000,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b1,1'b0,32'hDEAD_BEEF,16'h0020);
      add(1'b1,1'b1,1'b1,1'b0,32'h0000_0304,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b0,1'b1,32'h1111_0000,16'h0020);
      add(1'b1,1'b1,1'b1,1'b0,32'h0000_0308,32'h0000_0000,4'hF,1'b1,32'h2222_0000,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b1,1'b0,32'h1111_0000,16'h0020);
      add(1'b1,1'b1,1'b1,1'b0,32'h0000_0308,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b0,1'b1,32'h2222_0000,16'h0020);
      add(1'b1,1'b1,1'b1,1'b0,32'h0000_030C,32'h0000_0000,4'hF,1'b1,32'h3333_0000,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b1,1'b0,32'h2222_0000,16'h0020);
      add(1'b1,1'b1,1'b1,1'b0,32'h0000_030C,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b0,1'b1,32'h3333_0000,16'h0020);
      bus(27'h000_030C, 32'h0000_0000, 4'h0);
      add(1'b1,1'b0,1'b0,1'b0,32'h0000_030C,32'h0000_0000,4'hF,1'b1,32'h4444_0000,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b1,1'b0,32'h3333_0000,16'h0020);
      add(1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hF,1'b1,1'b1,1'b0,1'b0,32'h4444_0000,16'h0020);
      // request outside the external space is ignored
      add(1'b1,1'b1,1'b0,1'b0,32'hFFFF_FE71,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hF,1'b1,1'b1,1'b0,1'b0,32'h4444_0000,16'h0020);
      add(1'b1,1'b1,1'b0,1'b0,32'hFFFF_FE71,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hF,1'b1,1'b1,1'b0,1'b0,32'h4444_0000,16'h0020);
      // unlocked request arriving in T2 is taken from IDLE
      add(1'b1,1'b1,1'b0,1'b0,32'h0000_0400,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hF,1'b1,1'b1,1'b0,1'b1,32'h4444_0000,16'h0020);
      add(1'b1,1'b1,1'b0,1'b0,32'h0000_0400,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b0,1'b1,32'h4444_0000,16'h0020);
      add(1'b1,1'b1,1'b0,1'b0,32'h0000_0500,32'h0000_0000,4'hF,1'b1,32'h6666_0000,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b1,1'b0,32'h4444_0000,16'h0020);
      add(1'b1,1'b1,1'b0,1'b0,32'h0000_0500,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hF,1'b1,1'b1,1'b0,1'b1,32'h6666_0000,16'h0020);
      add(1'b1,1'b1,1'b0,1'b0,32'h0000_0500,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b0,1'b1,32'h6666_0000,16'h0020);
      add(1'b1,1'b0,1'b0,1'b0,32'h0000_0500,32'h0000_0000,4'hF,1'b1,32'h7777_0000,1'b0,16'h0000, 4'hE,1'b0,1'b1,1'b1,1'b0,32'h6666_0000,16'h0020);
      add(1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hF,1'b1,1'b1,1'b0,1'b0,32'h7777_0000,16'h0020);
      // WCR rewritten in T1 does not disturb the loaded count; CE=0 freezes a TW cycle
      add(1'b1,1'b1,1'b0,1'b0,32'h1000_0080,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hF,1'b1,1'b1,1'b0,1'b1,32'h7777_0000,16'h0020);
      add(1'b1,1'b1,1'b0,1'b0,32'h1000_0080,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b1,16'h0000, 4'hB,1'b0,1'b1,1'b0,1'b1,32'h7777_0000,16'h0020);
      add(1'b0,1'b1,1'b0,1'b0,32'h1000_0080,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b1,16'h00FF, 4'hB,1'b0,1'b1,1'b0,1'b1,32'h7777_0000,16'h0000);
      add(1'b1,1'b1,1'b0,1'b0,32'h1000_0080,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hB,1'b0,1'b1,1'b0,1'b1,32'h7777_0000,16'h0000);
      add(1'b1,1'b1,1'b0,1'b0,32'h1000_0080,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hB,1'b0,1'b1,1'b0,1'b1,32'h7777_0000,16'h0000);
      add(1'b1,1'b0,1'b0,1'b0,32'h1000_0080,32'h0000_0000,4'hF,1'b1,32'h5555_0000,1'b0,16'h0000, 4'hB,1'b0,1'b1,1'b1,1'b0,32'h7777_0000,16'h0000);
      add(1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,4'hF,1'b1,32'h0000_0000,1'b0,16'h0000, 4'hF,1'b1,1'b1,1'b0,1'b0,32'h5555_0000,16'h0000);

      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;

      for (int i = 0; i < tv.size(); i++) begin
         CE = tv[i].ce; DBUS_REQ = tv[i].req; DBUS_LOCK = tv[i].lock; DBUS_WE = tv[i].we;
         DBUS_A = tv[i].a; DBUS_DO = tv[i].dout; DBUS_BA = tv[i].ba; MEM_WAIT_N = tv[i].wn;
         MEM_DI = tv[i].mdi; REG_WE = tv[i].rwe; REG_DI = tv[i].rdi;
         #1;
         chk($sformatf("v%0d cs_n", i), {28'd0, CS_N}, {28'd0, tv[i].e_cs});
         chk($sformatf("v%0d rd_n", i), {31'd0, MEM_RD_N}, {31'd0, tv[i].e_rd});
         chk($sformatf("v%0d wr_n", i), {31'd0, MEM_WR_N}, {31'd0, tv[i].e_wr});
         chk($sformatf("v%0d ack", i), {31'd0, BSC_ACK}, {31'd0, tv[i].e_ack});
         chk($sformatf("v%0d wait", i), {31'd0, DBUS_WAIT}, {31'd0, tv[i].e_wt});
         chk($sformatf("v%0d dbus_di", i), DBUS_DI, tv[i].e_di);
         chk($sformatf("v%0d reg_do", i), {16'd0, REG_DO}, {16'd0, tv[i].e_reg});
         if (tv[i].chk_bus) begin
            chk($sformatf("v%0d mem_a", i), {5'd0, MEM_A}, {5'd0, tv[i].e_a});
            chk($sformatf("v%0d mem_do", i), MEM_DO, tv[i].e_do);
            chk($sformatf("v%0d mem_be_n", i), {28'd0, MEM_BE_N}, {28'd0, tv[i].e_be});
         end else begin
            n_checks = n_checks;
         end
         @(posedge CLK);
         #1;
      end

      // Reset asserted in the middle of a wait-state cycle aborts it at once.
      drive_idle();
      REG_WE = 1'b1;
      REG_DI = 16'h0003;
      #1;
      @(posedge CLK);
      #1;
      REG_WE = 1'b0;
      DBUS_REQ = 1'b1;
      DBUS_A = 32'h0000_0000;
      DBUS_BA = 4'hF;
      #1;
      chk("rst idle wait", {31'd0, DBUS_WAIT}, 32'd1);
      @(posedge CLK);
      #1;
      chk("rst t1 cs_n", {28'd0, CS_N}, 32'hE);
      @(posedge CLK);
      #1;
      DBUS_REQ = 1'b0;
      #1;
      chk("rst tw cs_n", {28'd0, CS_N}, 32'hE);
      chk("rst tw rd_n", {31'd0, MEM_RD_N}, 32'd0);
      chk("rst tw wait", {31'd0, DBUS_WAIT}, 32'd1);
      #1;
      RST = 1'b1;
      #1;
      chk("rst async cs_n", {28'd0, CS_N}, 32'hF);
      chk("rst async rd_n", {31'd0, MEM_RD_N}, 32'd1);
      chk("rst async wr_n", {31'd0, MEM_WR_N}, 32'd1);
      chk("rst async be_n", {28'd0, MEM_BE_N}, 32'hF);
      chk("rst async ack", {31'd0, BSC_ACK}, 32'd0);
      chk("rst async wait", {31'd0, DBUS_WAIT}, 32'd0);
      chk("rst async dbus_di", DBUS_DI, 32'd0);
      chk("rst async reg_do", {16'd0, REG_DO}, 32'h0000_00FF);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("post rst %0d ack", k), {31'd0, BSC_ACK}, 32'd0);
         chk($sformatf("post rst %0d cs_n", k), {28'd0, CS_N}, 32'hF);
         @(posedge CLK);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
